// File: rtl/regex_pc_scheduler_if.sv
// Handshake bundle between the regex PC scheduler, its run controller and the
// regex CPU. The scheduler takes the slave side.
interface regex_pc_scheduler_if #(
  parameter int PC_WIDTH    = 8,
  parameter int CC_ID_BITS  = 1,
  parameter int COUNT_WIDTH = 16
);
  logic                   start;
  logic [PC_WIDTH-1:0]    start_pc;
  logic [CC_ID_BITS-1:0]  start_cc_id;
  logic                   busy;
  logic                   done;
  logic                   accepted;
  logic                   overflow;
  logic [COUNT_WIDTH-1:0] dispatch_count;
  logic                   cpu_pc_valid;
  logic [PC_WIDTH-1:0]    cpu_pc;
  logic [CC_ID_BITS-1:0]  cpu_cc_id;
  logic                   cpu_pc_ready;
  logic                   cpu_out_pc_valid;
  logic [PC_WIDTH-1:0]    cpu_out_pc;
  logic [CC_ID_BITS-1:0]  cpu_out_cc_id;
  logic                   cpu_out_pc_ready;
  logic                   cpu_accepts;

  modport slave (
    input  start, start_pc, start_cc_id, cpu_pc_ready,
           cpu_out_pc_valid, cpu_out_pc, cpu_out_cc_id, cpu_accepts,
    output busy, done, accepted, overflow, dispatch_count,
           cpu_pc_valid, cpu_pc, cpu_cc_id, cpu_out_pc_ready
  );

  modport master (
    output start, start_pc, start_cc_id, cpu_pc_ready,
           cpu_out_pc_valid, cpu_out_pc, cpu_out_cc_id, cpu_accepts,
    input  busy, done, accepted, overflow, dispatch_count,
           cpu_pc_valid, cpu_pc, cpu_cc_id, cpu_out_pc_ready
  );
endinterface

// File: rtl/regex_pc_scheduler.sv
// Pending-thread scheduler for a regex CPU: queues {cc_id, pc} threads in a FIFO,
// hands them to the CPU one at a time and decides when a match run terminates.
module regex_pc_scheduler #(
  parameter int PC_WIDTH        = 8,
  parameter int CC_ID_BITS      = 1,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  regex_pc_scheduler_if.slave  bus
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int EW    = CC_ID_BITS + PC_WIDTH;
  localparam int AW    = FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic                   in_flight_q, in_flight_d;
  logic                   accepted_q, accepted_d;
  logic                   overflow_q, overflow_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [EW-1:0]          mem_q [DEPTH];

  logic                   fifo_empty_s;
  logic                   fifo_full_s;
  logic                   pop_s;
  logic                   push_req_s;
  logic                   wr_en_s;
  logic [AW-1:0]          wr_idx_s;
  logic [EW-1:0]          wr_data_s;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign bus.cpu_pc_valid     = (state_q == ST_RUN) && !fifo_empty_s && !in_flight_q;
  assign {bus.cpu_cc_id, bus.cpu_pc} = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_s                = bus.cpu_pc_valid && bus.cpu_pc_ready;
  assign bus.cpu_out_pc_ready = (state_q == ST_RUN);
  assign push_req_s           = bus.cpu_out_pc_valid && bus.cpu_out_pc_ready;

  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.done           = (state_q == ST_FINISH);
  assign bus.accepted       = accepted_q;
  assign bus.overflow       = overflow_q;
  assign bus.dispatch_count = count_q;

  // Next-state, FIFO pointer and run-result logic.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    in_flight_d = in_flight_q;
    accepted_d  = accepted_q;
    overflow_d  = overflow_q;
    count_d     = count_q;
    wr_en_s     = 1'b0;
    wr_idx_s    = wr_ptr_q[AW-1:0];
    wr_data_s   = {bus.cpu_out_cc_id, bus.cpu_out_pc};

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_RUN;
          rd_ptr_d    = {(AW+1){1'b0}};
          wr_ptr_d    = {{AW{1'b0}}, 1'b1};
          wr_en_s     = 1'b1;
          wr_idx_s    = {AW{1'b0}};
          wr_data_s   = {bus.start_cc_id, bus.start_pc};
          in_flight_d = 1'b0;
          accepted_d  = 1'b0;
          overflow_d  = 1'b0;
          count_d     = {COUNT_WIDTH{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (pop_s) begin
          rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, 1'b1};
          in_flight_d = 1'b1;
          if (count_q != {COUNT_WIDTH{1'b1}}) begin
            count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
          end else begin
            count_d = count_q;
          end
        end else if (in_flight_q && bus.cpu_pc_ready && !bus.cpu_out_pc_valid) begin
          in_flight_d = 1'b0;
        end else begin
          in_flight_d = in_flight_q;
        end

        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        if (push_req_s && (!fifo_full_s || pop_s)) begin
          wr_en_s  = 1'b1;
          wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
          wr_en_s  = 1'b0;
        end

        if (bus.cpu_accepts) begin
          accepted_d = 1'b1;
          overflow_d = 1'b0;
          state_d    = ST_FINISH;
          wr_ptr_d   = {(AW+1){1'b0}};
          rd_ptr_d   = {(AW+1){1'b0}};
        end else if (push_req_s && fifo_full_s && !pop_s) begin
          accepted_d = 1'b0;
          overflow_d = 1'b1;
          state_d    = ST_FINISH;
          wr_ptr_d   = {(AW+1){1'b0}};
          rd_ptr_d   = {(AW+1){1'b0}};
        end else if (fifo_empty_s && !in_flight_q && !push_req_s) begin
          accepted_d = 1'b0;
          overflow_d = 1'b0;
          state_d    = ST_FINISH;
          wr_ptr_d   = {(AW+1){1'b0}};
          rd_ptr_d   = {(AW+1){1'b0}};
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= {(AW+1){1'b0}};
      rd_ptr_q    <= {(AW+1){1'b0}};
      in_flight_q <= 1'b0;
      accepted_q  <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= {COUNT_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_flight_q <= in_flight_d;
      accepted_q  <= accepted_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
    end
  end

  // Thread storage; contents are meaningful only between the pointers.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= wr_data_s;
    end
  end

endmodule

// File: doc/regex_pc_scheduler.md
REGEX_PC_SCHEDULER -- requirements
Module: regex_pc_scheduler

Interface
REQ-001 Parameter PC_WIDTH, default 8, width of program counter.
REQ-002 Parameter CC_ID_BITS, default 1, width of character-context id.
REQ-003 Parameter FIFO_DEPTH_LOG2, default 4, log2 of pending-thread FIFO depth (16 entries).
REQ-004 Parameter COUNT_WIDTH, default 16, width of dispatch counter.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-007 start  input  1  one-cycle request to begin a match run.
REQ-008 start_pc  input  PC_WIDTH  initial thread PC, sampled with start.
REQ-009 start_cc_id  input  CC_ID_BITS  initial thread context id, sampled with start.
REQ-010 busy  output  1  high while a run is active.
REQ-011 done  output  1  one-cycle pulse when a run terminates.
REQ-012 accepted  output  1  result of last run; valid from done pulse until next start.
REQ-013 overflow  output  1  last run aborted by FIFO overflow; valid like accepted.
REQ-014 dispatch_count  output  COUNT_WIDTH  PCs dispatched in current/last run, saturating.
REQ-015 cpu_pc_valid / cpu_pc / cpu_cc_id  output  1 / PC_WIDTH / CC_ID_BITS  thread offered to CPU input.
REQ-016 cpu_pc_ready  input  1  CPU idle and able to take a PC.
REQ-017 cpu_out_pc_valid / cpu_out_pc / cpu_out_cc_id  input  1 / PC_WIDTH / CC_ID_BITS  thread produced by CPU.
REQ-018 cpu_out_pc_ready  output  1  scheduler accepts CPU-produced thread.
REQ-019 cpu_accepts  input  1  CPU executed an accepting instruction.

Function
REQ-020 States SHALL be IDLE, RUN, FINISH; FINISH lasts exactly one cycle then returns to IDLE.
REQ-021 IDLE + start: flush FIFO, push {start_cc_id,start_pc}, clear dispatch_count, accepted, overflow, in_flight; next state RUN.
REQ-022 start SHALL be ignored in RUN and FINISH.
REQ-023 busy SHALL be high in RUN and FINISH, low in IDLE.
REQ-024 cpu_pc_valid SHALL equal (state==RUN && FIFO not empty && !in_flight); cpu_pc/cpu_cc_id SHALL present FIFO head.
REQ-025 Dispatch handshake = cpu_pc_valid && cpu_pc_ready: pop head, set in_flight, increment dispatch_count (saturate at all-ones).
REQ-026 in_flight SHALL clear on any cycle after the dispatch cycle where cpu_pc_ready==1 and cpu_out_pc_valid==0.
REQ-027 cpu_out_pc_ready SHALL be 1 in RUN, 0 otherwise; a push occurs on cpu_out_pc_valid && cpu_out_pc_ready.
REQ-028 Simultaneous push and pop SHALL be legal at any occupancy including full; occupancy unchanged.
REQ-029 Push while full without simultaneous pop: entry dropped, overflow=1, accepted=0, go to FINISH.
REQ-030 cpu_accepts==1 in RUN: accepted=1, go to FINISH; takes priority over overflow in same cycle (overflow stays 0).
REQ-031 FIFO empty, in_flight==0, no push this cycle, in RUN: accepted=0, overflow=0, go to FINISH.
REQ-032 done SHALL be 1 exactly in FINISH; FIFO SHALL be flushed on entry to FINISH.
REQ-033 FIFO pointers SHALL be FIFO_DEPTH_LOG2+1 bits with wrap-around; full when MSBs differ and remaining bits equal.
REQ-034 Latency: start to first cpu_pc_valid = 1 cycle; CPU output pushed into empty FIFO re-offered the cycle after in_flight clears.

Reset
REQ-035 rst==0 SHALL immediately force IDLE, empty FIFO, in_flight=0, busy=0, done=0, accepted=0, overflow=0, dispatch_count=0, cpu_pc_valid=0, cpu_out_pc_ready=0.
REQ-036 Reset mid-run SHALL abort without a done pulse; first start after rst rises SHALL behave as from power-up.

Verification
REQ-037 start pc=0x05 cc=0; CPU takes it, then ready with no output -> one dispatch, done pulse, accepted=0, overflow=0, dispatch_count=1.
REQ-038 start pc=0x10; CPU returns 0x11, then 0x12, then cpu_accepts -> cpu_pc sequence 0x10,0x11,0x12, accepted=1, dispatch_count=3.
REQ-039 CPU returns two PCs (0x20 cc0, 0x30 cc1) per dispatch -> FIFO order preserved, cpu_cc_id matches each pushed entry.
REQ-040 Hold cpu_pc_ready=0, drive 17 pushes after one dispatch -> 16 accepted, 17th sets overflow=1, accepted=0, done pulse.
REQ-041 cpu_accepts and overflowing push in same cycle -> accepted=1, overflow=0.
REQ-042 Assert rst=0 mid-run with 5 entries queued -> outputs reset same cycle, no done; new start pc=0x01 runs normally.
